// File: rtl/vga_fb_write_arbiter.sv
// ============================================================================
// Module   : vga_fb_write_arbiter
// Purpose  : Round-robin write-port arbiter for a 1-bit VGA frame buffer,
//            with an optional blanking-only write window and a clear engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_fb_write_arbiter #(
  parameter int X_MAX          = 159,
  parameter int Y_MAX          = 119,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        VBLANK,
  input  logic        BLANK_ONLY,
  input  logic        CLEAR_REQ,
  input  logic        CLEAR_VAL,
  input  logic        A_REQ,
  input  logic [14:0] A_ADDR,
  input  logic        A_DATA,
  output logic        A_GNT,
  input  logic        B_REQ,
  input  logic [14:0] B_ADDR,
  input  logic        B_DATA,
  output logic        B_GNT,
  output logic        FB_WE,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        BUSY,
  output logic        CLEAR_DONE,
  output logic        DROP
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [7:0] c_X_MAX = 8'(X_MAX);
  localparam logic [6:0] c_Y_MAX = 7'(Y_MAX);

  state_t      r_state;
  logic        r_ptr_b;
  logic [7:0]  r_clr_x;
  logic [6:0]  r_clr_y;
  logic        r_clr_val;
  logic        r_fb_we;
  logic [14:0] r_fb_addr;
  logic        r_fb_data;
  logic        r_done;
  logic        r_drop;

  state_t      w_state_nxt;
  logic        w_ptr_b_nxt;
  logic [7:0]  w_clr_x_nxt;
  logic [6:0]  w_clr_y_nxt;
  logic        w_clr_val_nxt;
  logic        w_we_nxt;
  logic [14:0] w_addr_nxt;
  logic        w_data_nxt;
  logic        w_done_nxt;
  logic        w_drop_nxt;
  logic        w_win;
  logic        w_gnt_a;
  logic        w_gnt_b;
  logic [14:0] w_sel_addr;
  logic        w_sel_data;

  assign w_win = ~BLANK_ONLY | VBLANK;

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_b_nxt   = r_ptr_b;
    w_clr_x_nxt   = r_clr_x;
    w_clr_y_nxt   = r_clr_y;
    w_clr_val_nxt = r_clr_val;
    w_we_nxt      = 1'b0;
    w_addr_nxt    = r_fb_addr;
    w_data_nxt    = r_fb_data;
    w_done_nxt    = 1'b0;
    w_drop_nxt    = 1'b0;
    w_gnt_a       = 1'b0;
    w_gnt_b       = 1'b0;
    w_sel_addr    = A_ADDR;
    w_sel_data    = A_DATA;

    case (r_state)
      S_IDLE: begin
        if (CLEAR_REQ) begin
          w_state_nxt   = S_CLEAR;
          w_clr_x_nxt   = 8'd0;
          w_clr_y_nxt   = 7'd0;
          w_clr_val_nxt = CLEAR_VAL;
        end else if (w_win) begin
          // r_ptr_b set means B has priority on the next contested cycle
          if (A_REQ && (!B_REQ || !r_ptr_b)) begin
            w_gnt_a = 1'b1;
          end else if (B_REQ) begin
            w_gnt_b = 1'b1;
          end
        end

        if (w_gnt_a || w_gnt_b) begin
          w_sel_addr  = w_gnt_a ? A_ADDR : B_ADDR;
          w_sel_data  = w_gnt_a ? A_DATA : B_DATA;
          w_ptr_b_nxt = w_gnt_a;
          w_addr_nxt  = w_sel_addr;
          w_data_nxt  = w_sel_data;
          if ((w_sel_addr[7:0] > c_X_MAX) || (w_sel_addr[14:8] > c_Y_MAX)) begin
            w_drop_nxt = 1'b1;
          end else begin
            w_we_nxt = 1'b1;
          end
        end
      end

      S_CLEAR: begin
        if (w_win) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = {r_clr_y, r_clr_x};
          w_data_nxt = r_clr_val;
          if (r_clr_x == c_X_MAX) begin
            w_clr_x_nxt = 8'd0;
            if (r_clr_y == c_Y_MAX) begin
              w_clr_y_nxt = 7'd0;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_clr_y_nxt = r_clr_y + 7'd1;
            end
          end else begin
            w_clr_x_nxt = r_clr_x + 8'd1;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_ptr_b   <= 1'b0;
      r_clr_x   <= 8'd0;
      r_clr_y   <= 7'd0;
      r_clr_val <= 1'b0;
      r_fb_we   <= 1'b0;
      r_fb_addr <= 15'd0;
      r_fb_data <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr_b   <= w_ptr_b_nxt;
      r_clr_x   <= w_clr_x_nxt;
      r_clr_y   <= w_clr_y_nxt;
      r_clr_val <= w_clr_val_nxt;
      r_fb_we   <= w_we_nxt;
      r_fb_addr <= w_addr_nxt;
      r_fb_data <= w_data_nxt;
      r_done    <= w_done_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  assign A_GNT      = w_gnt_a;
  assign B_GNT      = w_gnt_b;
  assign FB_WE      = r_fb_we;
  assign FB_ADDR    = r_fb_addr;
  assign FB_DATA    = r_fb_data;
  assign BUSY       = (r_state == S_CLEAR);
  assign CLEAR_DONE = r_done;
  assign DROP       = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_write_arbiter.sv
// ============================================================================
// Module   : tb_vga_fb_write_arbiter
// Purpose  : Directed self-checking bench: small 4x3 buffer plus a default
//            160x120 instance (no reset clear) for round-robin ordering.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_fb_write_arbiter;

  logic        CLK;
  logic        RESET;
  logic        VBLANK;
  logic        BLANK_ONLY;
  logic        CLEAR_REQ;
  logic        CLEAR_VAL;
  logic        A_REQ;
  logic [14:0] A_ADDR;
  logic        A_DATA;
  logic        B_REQ;
  logic [14:0] B_ADDR;
  logic        B_DATA;

  logic        A_GNT, B_GNT, FB_WE, FB_DATA, BUSY, CLEAR_DONE, DROP;
  logic [14:0] FB_ADDR;
  logic        big_A_GNT, big_B_GNT, big_FB_WE, big_FB_DATA, big_BUSY, big_CLEAR_DONE, big_DROP;
  logic [14:0] big_FB_ADDR;

  int n_checks = 0;
  int n_pass   = 0;

  vga_fb_write_arbiter #(.X_MAX(3), .Y_MAX(2), .CLEAR_ON_RESET(1'b1)) u_dut (
    .CLK(CLK), .RESET(RESET), .VBLANK(VBLANK), .BLANK_ONLY(BLANK_ONLY),
    .CLEAR_REQ(CLEAR_REQ), .CLEAR_VAL(CLEAR_VAL),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_GNT(A_GNT),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_GNT(B_GNT),
    .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA),
    .BUSY(BUSY), .CLEAR_DONE(CLEAR_DONE), .DROP(DROP)
  );

  vga_fb_write_arbiter #(.X_MAX(159), .Y_MAX(119), .CLEAR_ON_RESET(1'b0)) u_big (
    .CLK(CLK), .RESET(RESET), .VBLANK(VBLANK), .BLANK_ONLY(BLANK_ONLY),
    .CLEAR_REQ(CLEAR_REQ), .CLEAR_VAL(CLEAR_VAL),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_GNT(big_A_GNT),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_GNT(big_B_GNT),
    .FB_WE(big_FB_WE), .FB_ADDR(big_FB_ADDR), .FB_DATA(big_FB_DATA),
    .BUSY(big_BUSY), .CLEAR_DONE(big_CLEAR_DONE), .DROP(big_DROP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // inputs change 1 time unit after the edge; outputs are sampled at the falling edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] small_addr(input int k);
    return 16'(((k / 4) << 8) | (k % 4));
  endfunction

  int         seen [12];
  logic [11:0] all_once;
  logic       m_busy, exp_we, exp_last;
  logic [15:0] exp_addr;
  int         m_cnt;
  int         iter;

  initial begin
    RESET = 1'b1; VBLANK = 1'b0; BLANK_ONLY = 1'b0;
    CLEAR_REQ = 1'b0; CLEAR_VAL = 1'b0;
    A_REQ = 1'b1; A_ADDR = 15'h0001; A_DATA = 1'b1;
    B_REQ = 1'b0; B_ADDR = 15'h0000; B_DATA = 1'b0;

    // reset state
    tick(); tick(); #4;
    chk("rst_fb_we", 16'(FB_WE), 16'd0);
    chk("rst_fb_addr", 16'(FB_ADDR), 16'd0);
    chk("rst_fb_data", 16'(FB_DATA), 16'd0);
    chk("rst_drop", 16'(DROP), 16'd0);
    chk("rst_done", 16'(CLEAR_DONE), 16'd0);
    chk("rst_busy", 16'(BUSY), 16'd1);
    chk("rst_a_gnt", 16'(A_GNT), 16'd0);
    chk("rst_big_busy", 16'(big_BUSY), 16'd0);
    chk("rst_big_done", 16'(big_CLEAR_DONE), 16'd0);

    // reset clear: 12 writes, A held and granted only once BUSY falls
    tick(); RESET = 1'b0; #4;
    chk("rel_fb_we", 16'(FB_WE), 16'd0);
    for (int k = 0; k < 12; k++) begin
      tick(); #4;
      chk("rclr_we", 16'(FB_WE), 16'd1);
      chk("rclr_addr", 16'(FB_ADDR), small_addr(k));
      chk("rclr_data", 16'(FB_DATA), 16'd0);
      chk("rclr_done", 16'(CLEAR_DONE), (k == 11) ? 16'd1 : 16'd0);
      chk("rclr_busy", 16'(BUSY), (k == 11) ? 16'd0 : 16'd1);
      chk("rclr_a_gnt", 16'(A_GNT), (k == 11) ? 16'd1 : 16'd0);
    end
    tick(); A_REQ = 1'b0; #4;
    chk("rclr_a_we", 16'(FB_WE), 16'd1);
    chk("rclr_a_addr", 16'(FB_ADDR), 16'h0001);
    chk("rclr_a_data", 16'(FB_DATA), 16'd1);
    chk("rclr_done_low", 16'(CLEAR_DONE), 16'd0);
    chk("rclr_a_gnt_low", 16'(A_GNT), 16'd0);

    // round-robin on the 160x120 instance; a lone B grant first hands priority to A
    tick(); B_REQ = 1'b1; B_ADDR = 15'h0106; B_DATA = 1'b0; #4;
    chk("rr_solo_b_gnt", 16'(big_B_GNT), 16'd1);
    chk("rr_solo_a_gnt", 16'(big_A_GNT), 16'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      if (j == 0) begin
        A_REQ = 1'b1; A_ADDR = 15'h0005; A_DATA = 1'b1;
      end
      #4;
      chk("rr_a_gnt", 16'(big_A_GNT), (j % 2 == 0) ? 16'd1 : 16'd0);
      chk("rr_b_gnt", 16'(big_B_GNT), (j % 2 == 0) ? 16'd0 : 16'd1);
      chk("rr_fb_we", 16'(big_FB_WE), 16'd1);
      chk("rr_fb_addr", 16'(big_FB_ADDR), (j % 2 == 0) ? 16'h0106 : 16'h0005);
      chk("rr_fb_data", 16'(big_FB_DATA), (j % 2 == 0) ? 16'd0 : 16'd1);
    end
    tick(); A_REQ = 1'b0; B_REQ = 1'b0; #4;
    chk("rr_last_we", 16'(big_FB_WE), 16'd1);
    chk("rr_last_addr", 16'(big_FB_ADDR), 16'h0106);
    chk("rr_drop", 16'(big_DROP), 16'd0);
    tick(); #4;
    chk("rr_idle_we", 16'(big_FB_WE), 16'd0);

    // blanking gate
    tick(); BLANK_ONLY = 1'b1; VBLANK = 1'b0; A_REQ = 1'b1; A_ADDR = 15'h0102; A_DATA = 1'b1; #4;
    chk("blk_gnt0", 16'(A_GNT), 16'd0);
    chk("blk_we0", 16'(FB_WE), 16'd0);
    tick(); #4;
    chk("blk_gnt1", 16'(A_GNT), 16'd0);
    chk("blk_we1", 16'(FB_WE), 16'd0);
    tick(); VBLANK = 1'b1; #4;
    chk("blk_vb_gnt", 16'(A_GNT), 16'd1);
    tick(); VBLANK = 1'b0; #4;
    chk("blk_vb_off_gnt", 16'(A_GNT), 16'd0);
    chk("blk_vb_we", 16'(FB_WE), 16'd1);
    chk("blk_vb_addr", 16'(FB_ADDR), 16'h0102);
    chk("blk_vb_data", 16'(FB_DATA), 16'd1);
    tick(); BLANK_ONLY = 1'b0; #4;
    chk("blk_open_gnt", 16'(A_GNT), 16'd1);
    chk("blk_open_we0", 16'(FB_WE), 16'd0);
    tick(); A_REQ = 1'b0; #4;
    chk("blk_open_we1", 16'(FB_WE), 16'd1);

    // out-of-range X, out-of-range Y, then the in-range corner
    tick(); A_REQ = 1'b1; A_ADDR = 15'h00C8; #4;
    chk("oor_x_gnt", 16'(A_GNT), 16'd1);
    chk("oor_x_drop_pre", 16'(DROP), 16'd0);
    tick(); A_ADDR = 15'h0300; #4;
    chk("oor_y_gnt", 16'(A_GNT), 16'd1);
    chk("oor_x_we", 16'(FB_WE), 16'd0);
    chk("oor_x_drop", 16'(DROP), 16'd1);
    tick(); A_ADDR = 15'h0203; #4;
    chk("oor_y_we", 16'(FB_WE), 16'd0);
    chk("oor_y_drop", 16'(DROP), 16'd1);
    tick(); A_REQ = 1'b0; #4;
    chk("corner_we", 16'(FB_WE), 16'd1);
    chk("corner_addr", 16'(FB_ADDR), 16'h0203);
    chk("corner_drop", 16'(DROP), 16'd0);

    // clear with pending B, blanking-gated, second CLEAR_REQ mid-clear
    tick(); BLANK_ONLY = 1'b1; VBLANK = 1'b1; B_REQ = 1'b1; B_ADDR = 15'h0001; B_DATA = 1'b0;
    CLEAR_REQ = 1'b1; CLEAR_VAL = 1'b1; #4;
    chk("clr_req_b_gnt", 16'(B_GNT), 16'd0);
    chk("clr_req_busy", 16'(BUSY), 16'd0);
    for (int k = 0; k < 12; k++) seen[k] = 0;
    m_busy = 1'b1; m_cnt = 0; exp_we = 1'b0; exp_last = 1'b0; exp_addr = 16'd0;
    iter = 0;
    while ((m_busy || exp_we) && iter < 60) begin
      tick();
      CLEAR_REQ = (iter == 4);
      CLEAR_VAL = 1'b0;
      VBLANK    = ((iter % 4) < 2);
      #4;
      chk("clr_we", 16'(FB_WE), 16'(exp_we));
      if (exp_we) begin
        chk("clr_addr", 16'(FB_ADDR), exp_addr);
        chk("clr_data", 16'(FB_DATA), 16'd1);
      end
      chk("clr_done", 16'(CLEAR_DONE), 16'(exp_last));
      chk("clr_busy", 16'(BUSY), 16'(m_busy));
      chk("clr_b_gnt", 16'(B_GNT), 16'(!m_busy && VBLANK));
      if (FB_WE && FB_ADDR[7:0] < 8'd4 && FB_ADDR[14:8] < 7'd3)
        seen[int'(FB_ADDR[14:8]) * 4 + int'(FB_ADDR[7:0])]++;
      if (m_busy && VBLANK) begin
        exp_we   = 1'b1;
        exp_addr = small_addr(m_cnt);
        exp_last = (m_cnt == 11);
        m_cnt++;
        if (m_cnt == 12) m_busy = 1'b0;
      end else begin
        exp_we   = 1'b0;
        exp_last = 1'b0;
      end
      iter++;
    end
    chk("clr_timeout", 16'(iter < 60), 16'd1);
    for (int k = 0; k < 12; k++) all_once[k] = (seen[k] == 1);
    chk("clr_all_once", 16'(all_once), 16'h0FFF);
    tick(); B_REQ = 1'b0; CLEAR_REQ = 1'b0;

    // reset mid-clear
    tick(); BLANK_ONLY = 1'b0; RESET = 1'b1;
    tick(); RESET = 1'b0; #4;
    chk("rmc_rel_we", 16'(FB_WE), 16'd0);
    for (int k = 0; k < 5; k++) begin
      tick(); #4;
      chk("rmc_we", 16'(FB_WE), 16'd1);
      chk("rmc_addr", 16'(FB_ADDR), small_addr(k));
    end
    tick(); RESET = 1'b1; #4;
    chk("rmc_pre_addr", 16'(FB_ADDR), small_addr(5));
    tick(); RESET = 1'b0; #4;
    chk("rmc_rst_we", 16'(FB_WE), 16'd0);
    chk("rmc_rst_addr", 16'(FB_ADDR), 16'd0);
    chk("rmc_rst_busy", 16'(BUSY), 16'd1);
    tick(); #4;
    chk("rmc_restart_we", 16'(FB_WE), 16'd1);
    chk("rmc_restart_addr0", 16'(FB_ADDR), 16'h0000);
    tick(); #4;
    chk("rmc_restart_addr1", 16'(FB_ADDR), 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_fb_write_arbiter.md
Name: vga_fb_write_arbiter

Overview:
- Owns the single write port of the 160x120 1-bit VGA frame buffer. The VGA signal generator owns the read port.
- Shares the write port between two requesters: A (microprocessor bus) and B (pattern/sprite engine). Arbitration is round-robin.
- Optionally restricts writes to vertical blanking, so the frame being scanned out does not tear.
- Contains a clear engine that fills the whole buffer with a constant value, after reset or on request.

Parameters:
- X_MAX, 159, last valid column (X field width 8 bits)
- Y_MAX, 119, last valid row (Y field width 7 bits)
- CLEAR_ON_RESET, 1, if 1 a full clear starts automatically when RESET is released

Ports:
- CLK  in  1  system clock; the frame buffer write port is also clocked by CLK
- RESET  in  1  synchronous, active-high reset
- VBLANK  in  1  high while the VGA generator is outside the active vertical region
- BLANK_ONLY  in  1  1 = writes (requests and clear) allowed only while VBLANK=1
- CLEAR_REQ  in  1  single-cycle pulse that starts a clear
- CLEAR_VAL  in  1  pixel value written by the clear
- A_REQ  in  1  requester A write request
- A_ADDR  in  15  {Y[6:0],X[7:0]}
- A_DATA  in  1  pixel value from A
- A_GNT  out  1  A's request accepted this cycle (combinational)
- B_REQ, B_ADDR, B_DATA, B_GNT  same as A, for requester B
- FB_WE  out  1  frame buffer write enable
- FB_ADDR  out  15  frame buffer write address {Y,X}
- FB_DATA  out  1  frame buffer write data
- BUSY  out  1  clear in progress
- CLEAR_DONE  out  1  one-cycle pulse when the last clear write is issued
- DROP  out  1  one-cycle pulse when a granted request is out of range

Behaviour:
- Reset values: FB_WE=0, FB_ADDR=0, FB_DATA=0, CLEAR_DONE=0, DROP=0, round-robin pointer favours A.
- State after reset: CLEAR with X=Y=0 and value 0 if CLEAR_ON_RESET=1, else IDLE. BUSY reflects that state.
- Reset asserted mid-clear aborts the clear immediately. No FB_WE is issued in the reset cycle.
- Write window: WIN = ~BLANK_ONLY | VBLANK.
- State machine has two states, IDLE and CLEAR.
- IDLE, grant rule:
  - A grant is issued only when WIN=1 and CLEAR_REQ=0.
  - If exactly one REQ is high, that requester is granted.
  - If both are high, grant goes to the requester not granted most recently; the pointer updates on every grant.
  - GNT is combinational from the REQ inputs, the pointer, the state and WIN. At most one GNT is high per cycle.
- Write latency: on a grant cycle the winner's ADDR/DATA are registered. FB_WE/FB_ADDR/FB_DATA appear the next cycle. FB_WE is high for exactly one cycle per accepted write.
- Throughput: a requester may hold REQ high with new ADDR/DATA on consecutive cycles, giving one write per cycle.
- REQ/ADDR/DATA must stay stable until GNT is seen.
- Range check: if the granted X > X_MAX or Y > Y_MAX, the grant still occurs but FB_WE stays 0 the next cycle and DROP pulses instead.
- IDLE -> CLEAR:
  - Triggered by CLEAR_REQ=1.
  - CLEAR_VAL is latched and the clear counters are set to X=0, Y=0.
  - Requests in the same cycle are not granted.
- CLEAR:
  - No grants.
  - Each cycle with WIN=1 issues one registered write {Y,X} of the latched value, with the same one-cycle latency as requester writes.
  - Scan order: X increments; at X_MAX, X wraps to 0 and Y increments.
  - When WIN=0 the counters hold and FB_WE=0.
- CLEAR -> IDLE:
  - Occurs in the cycle the write for (X_MAX,Y_MAX) is issued to the registers. CLEAR_DONE pulses in the same cycle as that FB_WE. BUSY falls with the transition.
  - Total writes: (X_MAX+1)*(Y_MAX+1) = 19200 by default.
- CLEAR_REQ while already in CLEAR is ignored; it does not restart the clear.
- A BLANK_ONLY change takes effect in the same cycle.
- Requests pending when WIN drops simply wait; no grant occurs while WIN=0.

Test Plan:
- Reset clear: X_MAX=3, Y_MAX=2, CLEAR_ON_RESET=1, BLANK_ONLY=0, release RESET -> 12 consecutive FB_WE pulses, addresses 0x0000..0x0003, 0x0100..0x0103, 0x0200..0x0203, FB_DATA=0; CLEAR_DONE with the 12th write; BUSY low afterwards; A_REQ held throughout is granted only after BUSY falls.
- Round-robin: A_REQ and B_REQ both held for 4 cycles, addresses 0x0005/0x0106 -> GNT order A,B,A,B; FB writes alternate 0x0005, 0x0106, one cycle behind each grant.
- Blanking gate: BLANK_ONLY=1, VBLANK=0, A_REQ held -> no A_GNT and FB_WE=0; raise VBLANK -> A_GNT the same cycle, FB_WE the next cycle; drop BLANK_ONLY with VBLANK=0 -> grants resume immediately.
- Out-of-range: A_ADDR = {Y=0,X=200} granted -> A_GNT=1, next cycle FB_WE=0 and DROP=1.
- Clear pause and collision: CLEAR_REQ with CLEAR_VAL=1 while B_REQ is high, BLANK_ONLY=1, VBLANK toggling -> no B_GNT in the CLEAR_REQ cycle; clear writes only while VBLANK=1 with the counters holding otherwise; second CLEAR_REQ mid-clear ignored; the full address set is written exactly once.
- Reset mid-clear: RESET asserted after 5 clear writes (CLEAR_ON_RESET=1) -> FB_WE=0 during reset, then the clear restarts at 0x0000.
